// File: rtl/hbridge_pwm_driver_pkg.sv
// Shared definitions for the H-bridge PWM driver: command encoding,
// channel state encoding and default timing parameters.
package hbridge_pwm_driver_pkg;

    localparam logic [1:0] CMD_COAST = 2'b00;
    localparam logic [1:0] CMD_REV   = 2'b01;
    localparam logic [1:0] CMD_FWD   = 2'b10;
    localparam logic [1:0] CMD_BRAKE = 2'b11;

    localparam int DEF_PRESC_DIV    = 10;
    localparam int DEF_DEAD_CYC     = 50000;
    localparam int DEF_RAMP_PERIODS = 4;

    typedef enum logic [1:0] {
        ST_COAST = 2'd0,
        ST_BRAKE = 2'd1,
        ST_DEAD  = 2'd2,
        ST_RUN   = 2'd3
    } ch_state_t;

endpackage

// File: rtl/hbridge_channel.sv
// One H-bridge channel: direction FSM with dead time, duty ramp and PWM
// enable compare. All outputs come straight from registers.
module hbridge_channel
    import hbridge_pwm_driver_pkg::*;
#(
    parameter int DEAD_CYC     = DEF_DEAD_CYC,
    parameter int RAMP_PERIODS = DEF_RAMP_PERIODS
) (
    input  logic       clk1,
    input  logic       rst_n,
    input  logic [1:0] cmd,
    input  logic [7:0] duty_max,
    input  logic [7:0] pwm_cnt_nxt,
    input  logic       period_start,
    output logic [1:0] pins,
    output logic       en,
    output logic       dead
);

    localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam int RW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYC - 1);
    localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_PERIODS - 1);

    ch_state_t     state_r, state_s;
    logic          dir_fwd_r, dir_fwd_s;
    logic [DW-1:0] dead_cnt_r, dead_cnt_s;
    logic [RW-1:0] ramp_cnt_r, ramp_cnt_s;
    logic [7:0]    duty_r, duty_s;
    logic [1:0]    pins_r, pins_s;
    logic          en_r, en_s;
    logic          dead_r, dead_s;
    logic          want_fwd_s;

    // Next-state, dead/ramp counters and output decode from the next state
    always_comb begin
        state_s    = state_r;
        dir_fwd_s  = dir_fwd_r;
        dead_cnt_s = dead_cnt_r;
        ramp_cnt_s = {RW{1'b0}};
        duty_s     = 8'd0;
        want_fwd_s = (cmd == CMD_FWD);
        pins_s     = 2'b00;
        en_s       = 1'b0;
        dead_s     = 1'b0;

        case (cmd)
            CMD_BRAKE: begin
                state_s    = ST_BRAKE;
                dead_cnt_s = {DW{1'b0}};
            end
            CMD_COAST: begin
                state_s    = ST_COAST;
                dead_cnt_s = {DW{1'b0}};
            end
            default: begin
                case (state_r)
                    ST_COAST, ST_BRAKE: begin
                        state_s    = ST_DEAD;
                        dir_fwd_s  = want_fwd_s;
                        dead_cnt_s = {DW{1'b0}};
                    end
                    ST_DEAD: begin
                        if (want_fwd_s != dir_fwd_r) begin
                            dir_fwd_s  = want_fwd_s;
                            dead_cnt_s = {DW{1'b0}};
                        end else if (dead_cnt_r == DEAD_LAST) begin
                            state_s    = ST_RUN;
                            dead_cnt_s = {DW{1'b0}};
                        end else begin
                            dead_cnt_s = dead_cnt_r + {{(DW-1){1'b0}}, 1'b1};
                        end
                    end
                    ST_RUN: begin
                        if (want_fwd_s != dir_fwd_r) begin
                            state_s    = ST_DEAD;
                            dir_fwd_s  = want_fwd_s;
                            dead_cnt_s = {DW{1'b0}};
                        end else begin
                            ramp_cnt_s = ramp_cnt_r;
                            if (period_start) begin
                                if (ramp_cnt_r == RAMP_LAST) begin
                                    ramp_cnt_s = {RW{1'b0}};
                                end else begin
                                    ramp_cnt_s = ramp_cnt_r + {{(RW-1){1'b0}}, 1'b1};
                                end
                            end else begin
                                ramp_cnt_s = ramp_cnt_r;
                            end
                            // A lowered ceiling wins over a ramp step in the same cycle
                            if (duty_r > duty_max) begin
                                duty_s = duty_max;
                            end else if (period_start && (ramp_cnt_r == RAMP_LAST) && (duty_r < duty_max)) begin
                                duty_s = duty_r + 8'd1;
                            end else begin
                                duty_s = duty_r;
                            end
                        end
                    end
                    default: begin
                        state_s = ST_COAST;
                    end
                endcase
            end
        endcase

        case (state_s)
            ST_BRAKE: begin
                pins_s = 2'b11;
                en_s   = 1'b1;
            end
            ST_DEAD: begin
                dead_s = 1'b1;
            end
            ST_RUN: begin
                pins_s = dir_fwd_s ? CMD_FWD : CMD_REV;
                en_s   = (pwm_cnt_nxt < duty_s);
            end
            default: begin
                pins_s = 2'b00;
            end
        endcase
    end

    // Channel state and registered pin outputs
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_r    <= ST_COAST;
            dir_fwd_r  <= 1'b0;
            dead_cnt_r <= {DW{1'b0}};
            ramp_cnt_r <= {RW{1'b0}};
            duty_r     <= 8'd0;
            pins_r     <= 2'b00;
            en_r       <= 1'b0;
            dead_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            dir_fwd_r  <= dir_fwd_s;
            dead_cnt_r <= dead_cnt_s;
            ramp_cnt_r <= ramp_cnt_s;
            duty_r     <= duty_s;
            pins_r     <= pins_s;
            en_r       <= en_s;
            dead_r     <= dead_s;
        end
    end

    assign pins = pins_r;
    assign en   = en_r;
    assign dead = dead_r;

endmodule

// File: rtl/hbridge_pwm_driver.sv
// Dual H-bridge PWM driver: shared prescaler and 8-bit PWM counter feeding
// two independent direction/dead-time/ramp channels.
module hbridge_pwm_driver
    import hbridge_pwm_driver_pkg::*;
#(
    parameter int PRESC_DIV    = DEF_PRESC_DIV,
    parameter int DEAD_CYC     = DEF_DEAD_CYC,
    parameter int RAMP_PERIODS = DEF_RAMP_PERIODS
) (
    input  logic       clk1,
    input  logic       rst_n,
    input  logic [1:0] cmd_a,
    input  logic [1:0] cmd_b,
    input  logic [7:0] duty_max,
    output logic       out_in1,
    output logic       out_in2,
    output logic       out_in3,
    output logic       out_in4,
    output logic       ena,
    output logic       enb,
    output logic [1:0] dead_active
);

    localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);

    logic [PW-1:0] presc_r, presc_s;
    logic [7:0]    pwm_cnt_r, pwm_cnt_s;
    logic          presc_wrap_s;
    logic          period_start_s;
    logic [1:0]    pins_a_s, pins_b_s;
    logic          en_a_s, en_b_s, dead_a_s, dead_b_s;

    // Channels compare against the counter value that will be live after the edge
    always_comb begin
        presc_wrap_s   = (presc_r == PRESC_LAST);
        period_start_s = presc_wrap_s && (pwm_cnt_r == 8'd0);
        if (presc_wrap_s) begin
            presc_s   = {PW{1'b0}};
            pwm_cnt_s = pwm_cnt_r + 8'd1;
        end else begin
            presc_s   = presc_r + {{(PW-1){1'b0}}, 1'b1};
            pwm_cnt_s = pwm_cnt_r;
        end
    end

    // Shared prescaler and PWM counter
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            presc_r   <= {PW{1'b0}};
            pwm_cnt_r <= 8'd0;
        end else begin
            presc_r   <= presc_s;
            pwm_cnt_r <= pwm_cnt_s;
        end
    end

    hbridge_channel #(
        .DEAD_CYC     (DEAD_CYC),
        .RAMP_PERIODS (RAMP_PERIODS)
    ) u_chan_a (
        .clk1         (clk1),
        .rst_n        (rst_n),
        .cmd          (cmd_a),
        .duty_max     (duty_max),
        .pwm_cnt_nxt  (pwm_cnt_s),
        .period_start (period_start_s),
        .pins         (pins_a_s),
        .en           (en_a_s),
        .dead         (dead_a_s)
    );

    hbridge_channel #(
        .DEAD_CYC     (DEAD_CYC),
        .RAMP_PERIODS (RAMP_PERIODS)
    ) u_chan_b (
        .clk1         (clk1),
        .rst_n        (rst_n),
        .cmd          (cmd_b),
        .duty_max     (duty_max),
        .pwm_cnt_nxt  (pwm_cnt_s),
        .period_start (period_start_s),
        .pins         (pins_b_s),
        .en           (en_b_s),
        .dead         (dead_b_s)
    );

    assign out_in1     = pins_a_s[1];
    assign out_in2     = pins_a_s[0];
    assign out_in3     = pins_b_s[1];
    assign out_in4     = pins_b_s[0];
    assign ena         = en_a_s;
    assign enb         = en_b_s;
    assign dead_active = {dead_b_s, dead_a_s};

endmodule

// File: doc/hbridge_pwm_driver.md
HBRIDGE_PWM_DRIVER -- requirements
Module: hbridge_pwm_driver

Interface
REQ-001 SHALL have parameter PRESC_DIV, default 10, which is the clk1 cycles per PWM count (50 MHz / 10 / 256 ≈ 19.5 kHz PWM).
REQ-002 SHALL have parameter DEAD_CYC, default 50000, which is the clk1 cycles of forced coast before applying a new direction (1 ms).
REQ-003 SHALL have parameter RAMP_PERIODS, default 4, which is the PWM periods per +1 step of effective duty.
REQ-004 SHALL have port clk1, input, 1 bit: the single system clock.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port cmd_a, input, 2 bits: {IN_1,IN_2} from the upstream motor controller.
REQ-007 SHALL have port cmd_b, input, 2 bits: {IN_3,IN_4} from the upstream motor controller.
REQ-008 SHALL have port duty_max, input, 8 bits: target PWM duty, shared by both channels.
REQ-009 SHALL have ports out_in1, out_in2, out_in3 and out_in4, outputs, 1 bit each: the H-bridge direction pins.
REQ-010 SHALL have ports ena and enb, outputs, 1 bit each: the H-bridge PWM enables.
REQ-011 SHALL have port dead_active, output, 2 bits: bit0 = channel A in DEAD, bit1 = channel B in DEAD.

Function
REQ-012 SHALL decode each cmd as: 10 = FWD, 01 = REV, 11 = BRAKE, 00 = COAST.
REQ-013 SHALL run a prescaler 0..PRESC_DIV-1; on prescaler wrap, pwm_cnt (8 bit) SHALL increment and wrap 255->0; pwm_cnt==0 at a wrap marks a period start.
REQ-014 SHALL run an independent state machine per channel, with states COAST, BRAKE, DEAD and RUN, plus a latched dir register.
REQ-015 On cmd BRAKE, any state SHALL go to BRAKE next cycle: pins 11, en=1, duty_eff=0, dead counter cleared.
REQ-016 On cmd COAST, any state SHALL go to COAST next cycle: pins 00, en=0, duty_eff=0, dead counter cleared.
REQ-017 On cmd FWD or REV, COAST and BRAKE SHALL go to DEAD, latching dir and zeroing the dead counter.
REQ-018 In RUN, a cmd direction different from the latched dir SHALL go to DEAD with the new dir latched and duty_eff=0.
REQ-019 DEAD SHALL drive pins 00 and en=0; after exactly DEAD_CYC cycles in DEAD, the channel SHALL go to RUN.
REQ-020 A reversal while in DEAD SHALL relatch dir and restart the dead counter from 0.
REQ-021 RUN SHALL drive pins 10 (FWD) or 01 (REV) and en = (pwm_cnt < duty_eff).
REQ-022 In RUN, duty_eff SHALL increment by 1 at every RAMP_PERIODS-th period start while duty_eff < duty_max; it SHALL never exceed duty_max.
REQ-023 If duty_max drops below duty_eff, duty_eff SHALL equal duty_max on the next cycle.
REQ-024 duty_max=0 SHALL give en constantly 0; duty_eff=255 SHALL give en high 255 of 256 counts.
REQ-025 All outputs SHALL be registered, with a latency of 1 clk1 cycle from the cmd sample to the pin change.
REQ-026 Pins 11 together with en=0, and any direction pins with en=1 outside RUN/BRAKE, SHALL never occur.

Reset
REQ-027 While rst_n=0 at a clk1 edge, both channels SHALL be forced to COAST, and all out_in*, ena, enb and dead_active SHALL be 0.
REQ-028 While rst_n=0 at a clk1 edge, prescaler, pwm_cnt, dead counters, ramp counters and duty_eff SHALL all be 0.
REQ-029 Reset asserted mid-DEAD or mid-RUN SHALL take effect at the next edge, with no completion of the dead time.

Structure
REQ-030 A shared package SHALL hold the cmd encoding constants, the channel state enum, and the default PRESC_DIV, DEAD_CYC and RAMP_PERIODS values.
REQ-031 The per-channel FSM, dead counter, ramp and en compare SHALL live in sub-module hbridge_channel, instantiated twice.
REQ-032 The prescaler and pwm_cnt SHALL be shared in the top level.

Verification (PRESC_DIV=1, DEAD_CYC=8, RAMP_PERIODS=1)
REQ-033 SHALL test reset: rst_n=0 for 3 cycles with cmd_a=10 -> all outputs 0; after release, dead_active[0]=1 for 8 cycles.
REQ-034 SHALL test startup: cmd_a 00->10, duty_max=128 -> out_in1/2=00 for 8 cycles, then 10; duty_eff reaches 128 after 128 periods; ena then high 128/256 counts.
REQ-035 SHALL test reversal: in RUN, cmd_a 10->01 -> next cycle pins 00, ena=0, dead_active[0]=1 for 8 cycles, then pins 01 with the ramp restarting from 0.
REQ-036 SHALL test brake during DEAD: cmd_b=11 at dead cycle 4 -> next cycle out_in3/4=11, enb=1, dead_active[1]=0.
REQ-037 SHALL test duty clamp: in RUN with duty_eff=200, duty_max set to 50 -> duty_eff=50 next cycle, and ena high 50/256 counts.
REQ-038 SHALL test channel independence: cmd_a=10 with cmd_b=01 simultaneously -> both channels sit in DEAD for 8 cycles, then out_in=1001, with identical ramps.
